// File: rtl/olo_intf_event_capture_pkg.sv
// Shared event codes, edge-mode encodings, long-press FSM states and the
// time-to-cycles helper used to size the debounce and long-press counters.
package olo_intf_event_capture_pkg;

    localparam logic [1:0] Evt_Press_c   = 2'b01;
    localparam logic [1:0] Evt_Release_c = 2'b10;
    localparam logic [1:0] Evt_Long_c    = 2'b11;

    localparam logic [1:0] Mode_Press_c   = 2'b01;
    localparam logic [1:0] Mode_Release_c = 2'b10;
    localparam logic [1:0] Mode_Both_c    = 2'b11;

    typedef enum logic [1:0] {
        LpIdle,
        LpHeld,
        LpLongDone
    } longPressState_t;

    // Rounds freq*time up to whole cycles, never less than one.
    function automatic int timeToCycles(input real freqHz, input real timeS);
        real prod;
        int  n;
        prod = freqHz * timeS;
        n    = int'(prod);
        if (real'(n) < prod) begin
            n = n + 1;
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/olo_intf_event_capture_ch.sv
// One input channel: 2-FF synchroniser, debounce, press/release detection
// and the long-press FSM. Events come out as a registered one-cycle pulse.
module olo_intf_event_capture_ch
    import olo_intf_event_capture_pkg::*;
#(
    parameter int   DebCnt_g    = 10,
    parameter int   LongCnt_g   = 100,
    parameter logic IdleLevel_g = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       InData,
    input  logic [1:0] EdgeMode,
    output logic       Level,
    output logic       EvtValid,
    output logic [1:0] EvtCode
);

    localparam int DebW_c  = $clog2(DebCnt_g + 1);
    localparam int LongW_c = $clog2(LongCnt_g + 1);
    localparam logic [DebW_c-1:0]  DebLast_c  = DebW_c'(DebCnt_g - 1);
    localparam logic [LongW_c-1:0] LongLast_c = LongW_c'(LongCnt_g - 1);

    logic [1:0]         syncReg;
    logic [DebW_c-1:0]  debCnt;
    logic [LongW_c-1:0] longCnt;
    longPressState_t    lpState;
    logic               toggle, pressNow, releaseNow, pressEn, releaseEn;

    always_comb begin
        toggle     = (syncReg[1] != Level) && (debCnt == DebLast_c);
        pressNow   = toggle && (Level == IdleLevel_g);
        releaseNow = toggle && (Level != IdleLevel_g);
        pressEn    = (EdgeMode == Mode_Press_c) || (EdgeMode == Mode_Both_c);
        releaseEn  = (EdgeMode == Mode_Release_c) || (EdgeMode == Mode_Both_c);
    end

    // Synchroniser resets to idle so an input held across reset still debounces into a press.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            syncReg <= {2{IdleLevel_g}};
            debCnt  <= '0;
            Level   <= IdleLevel_g;
        end else begin
            syncReg <= {syncReg[0], InData};
            if ((syncReg[1] == Level) || toggle) begin
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
            if (toggle) begin
                Level <= ~Level;
            end
        end
    end

    // Release has priority, so a release and a long press can never share a cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lpState  <= LpIdle;
            longCnt  <= '0;
            EvtValid <= 1'b0;
            EvtCode  <= '0;
        end else begin
            EvtValid <= 1'b0;
            if (releaseNow) begin
                lpState <= LpIdle;
                if (releaseEn) begin
                    EvtValid <= 1'b1;
                    EvtCode  <= Evt_Release_c;
                end
            end else begin
                case (lpState)
                    LpIdle: begin
                        if (pressNow) begin
                            lpState <= LpHeld;
                            longCnt <= '0;
                            if (pressEn) begin
                                EvtValid <= 1'b1;
                                EvtCode  <= Evt_Press_c;
                            end
                        end
                    end
                    LpHeld: begin
                        if (longCnt == LongLast_c) begin
                            lpState <= LpLongDone;
                            if (pressEn) begin
                                EvtValid <= 1'b1;
                                EvtCode  <= Evt_Long_c;
                            end
                        end else begin
                            longCnt <= longCnt + 1'b1;
                        end
                    end
                    LpLongDone: ;
                    default: lpState <= LpIdle;
                endcase
            end
        end
    end

endmodule

// File: rtl/olo_intf_event_capture.sv
// Multi-channel event capture: per-channel conditioners feed one pending slot
// each, a fixed-priority arbiter moves slots into a FIFO with a registered output.
module olo_intf_event_capture
    import olo_intf_event_capture_pkg::*;
#(
    parameter int   Channels_g      = 4,
    parameter real  ClkFrequency_g  = 125.0e6,
    parameter real  DebounceTime_g  = 25.0e-3,
    parameter real  LongPressTime_g = 1.0,
    parameter int   FifoDepth_g     = 16,
    parameter logic IdleLevel_g     = 1'b0,
    localparam int  ChW_c           = (Channels_g > 1) ? $clog2(Channels_g) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [Channels_g-1:0]   In_Data,
    input  logic [2*Channels_g-1:0] In_EdgeMode,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [ChW_c-1:0]        Out_Channel,
    output logic [1:0]              Out_Event,
    output logic [Channels_g-1:0]   Level,
    output logic                    Overflow,
    input  logic                    ClrOverflow
);

    localparam int DebCnt_c  = timeToCycles(ClkFrequency_g, DebounceTime_g);
    localparam int LongCnt_c = timeToCycles(ClkFrequency_g, LongPressTime_g);
    localparam int AddrW_c   = $clog2(FifoDepth_g);

    typedef struct packed {
        logic [ChW_c-1:0] chan;
        logic [1:0]       code;
    } fifoWord_t;

    logic [Channels_g-1:0] chEvtValid;
    logic [1:0]            chEvtCode [Channels_g];
    logic [Channels_g-1:0] slotValid;
    logic [1:0]            slotCode  [Channels_g];
    logic [Channels_g-1:0] grant;
    logic [Channels_g-1:0] drop;
    fifoWord_t             wrWord;
    fifoWord_t             mem [FifoDepth_g];
    logic [AddrW_c-1:0]    wrPtr, rdPtr;
    logic [AddrW_c:0]      memCount, fill;
    logic                  wrEn, fifoFull, loadOut;

    for (genvar c = 0; c < Channels_g; c++) begin : gChannel
        olo_intf_event_capture_ch #(
            .DebCnt_g    (DebCnt_c),
            .LongCnt_g   (LongCnt_c),
            .IdleLevel_g (IdleLevel_g)
        ) i_ch (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .InData   (In_Data[c]),
            .EdgeMode (In_EdgeMode[2*c+1 -: 2]),
            .Level    (Level[c]),
            .EvtValid (chEvtValid[c]),
            .EvtCode  (chEvtCode[c])
        );
    end

    // Fill counts the output register too, so total capacity is exactly FifoDepth_g.
    always_comb begin
        fill     = memCount + {{AddrW_c{1'b0}}, Out_Valid};
        fifoFull = (fill == (AddrW_c + 1)'(FifoDepth_g));
        loadOut  = (memCount != '0) && (!Out_Valid || Out_Ready);
        wrEn     = 1'b0;
        grant    = '0;
        wrWord   = '0;
        for (int c = 0; c < Channels_g; c++) begin
            if (slotValid[c] && !wrEn && !fifoFull) begin
                wrEn        = 1'b1;
                grant[c]    = 1'b1;
                wrWord.chan = ChW_c'(c);
                wrWord.code = slotCode[c];
            end
        end
        drop = chEvtValid & slotValid & ~grant;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            slotValid <= '0;
            Overflow  <= 1'b0;
            for (int c = 0; c < Channels_g; c++) begin
                slotCode[c] <= '0;
            end
        end else begin
            for (int c = 0; c < Channels_g; c++) begin
                if (chEvtValid[c] && (!slotValid[c] || grant[c])) begin
                    slotValid[c] <= 1'b1;
                    slotCode[c]  <= chEvtCode[c];
                end else if (grant[c]) begin
                    slotValid[c] <= 1'b0;
                end
            end
            if (|drop) begin
                Overflow <= 1'b1;
            end else if (ClrOverflow) begin
                Overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrWord;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            memCount    <= '0;
            Out_Valid   <= 1'b0;
            Out_Channel <= '0;
            Out_Event   <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (loadOut) begin
                rdPtr       <= rdPtr + 1'b1;
                Out_Valid   <= 1'b1;
                Out_Channel <= mem[rdPtr].chan;
                Out_Event   <= mem[rdPtr].code;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
            memCount <= memCount + (AddrW_c + 1)'(wrEn) - (AddrW_c + 1)'(loadOut);
        end
    end

endmodule
